// File: rtl/trisc_ctrl_pkg.sv
// trisc_ctrl_pkg: shared encodings for the TRISC control sequencer.
// State codes, opcode bit positions and control-word bit positions.
package trisc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_MEMRD  = 4'd2;
  localparam state_t S_IRLD   = 4'd3;
  localparam state_t S_DECODE = 4'd4;
  localparam state_t S_EX_ADD = 4'd5;
  localparam state_t S_EX_SUB = 4'd6;
  localparam state_t S_EX_LD  = 4'd7;
  localparam state_t S_EX_ST  = 4'd8;
  localparam state_t S_HALT   = 4'd9;
  localparam state_t S_TRAP   = 4'd10;

  localparam int OP_ADD  = 5;
  localparam int OP_SUB  = 4;
  localparam int OP_LD   = 3;
  localparam int OP_ST   = 2;
  localparam int OP_HALT = 0;

  localparam int PC_CLR  = 0;
  localparam int PC_INC  = 1;
  localparam int IR_LD   = 2;
  localparam int MAR_LD  = 3;
  localparam int MEM_RD  = 4;
  localparam int REG_RD  = 5;
  localparam int REG_WR  = 6;
  localparam int ALU_OE  = 7;
  localparam int ALU_SUB = 8;
  localparam int ALU_ADD = 9;
  localparam int MEM_WR  = 10;

endpackage

// File: rtl/trisc_op_decode.sv
// trisc_op_decode: one-hot opcode legality check and execute-state target.
// Ports: op (in, OP_W), legal (out), target (out, state_t).
module trisc_op_decode
  import trisc_ctrl_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] op,
  output logic            legal,
  output state_t          target
);

  localparam logic [OP_W-1:0] ONE = {{(OP_W-1){1'b0}}, 1'b1};
  localparam logic [OP_W-1:0] C_ADD = ONE << OP_ADD;
  localparam logic [OP_W-1:0] C_SUB = ONE << OP_SUB;
  localparam logic [OP_W-1:0] C_LD  = ONE << OP_LD;
  localparam logic [OP_W-1:0] C_ST  = ONE << OP_ST;
  localparam logic [OP_W-1:0] C_HLT = ONE << OP_HALT;

  // Whole-word compares: zero, multi-hot and
  // unassigned bits all fall through as illegal.
  always_comb begin
    legal  = 1'b1;
    target = S_IDLE;
    unique case (1'b1)
      (op == C_ADD): target = S_EX_ADD;
      (op == C_SUB): target = S_EX_SUB;
      (op == C_LD):  target = S_EX_LD;
      (op == C_ST):  target = S_EX_ST;
      (op == C_HLT): target = S_HALT;
      default:       legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/trisc_ctrl_seq.sv
// trisc_ctrl_seq: TRISC fetch/decode/execute control sequencer (negedge CLK).
// Ports: CLK, CLR (async low), run, op, mem_ready -> control, halted, trap,
// retired. Macro TRISC_CTRL_ILLEGAL_TRAP_EN: illegal op goes to TRAP.
module trisc_ctrl_seq
  import trisc_ctrl_pkg::*;
#(
  parameter int OP_W   = 11,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              run,
  input  logic [OP_W-1:0]   op,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] control,
  output logic              halted,
  output logic              trap,
  output logic [CNT_W-1:0]  retired
);

  state_t           r_state;
  state_t           w_next;
  logic             r_fresh;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_legal;
  state_t           w_target;
  logic [CTRL_W-1:0] w_ctrl;

  trisc_op_decode #(
    .OP_W (OP_W)
  ) u_dec (
    .op     (op),
    .legal  (w_legal),
    .target (w_target)
  );

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  w_next = S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_IRLD;
      S_IRLD:   w_next = S_DECODE;
      S_DECODE: begin
        if (w_legal) begin
          w_next = w_target;
        end else begin
`ifdef TRISC_CTRL_ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next   = S_IDLE;
          w_retire = 1'b1;
`endif
        end
      end
      S_EX_ADD, S_EX_SUB: begin
        w_next   = S_IDLE;
        w_retire = 1'b1;
      end
      S_EX_LD, S_EX_ST: begin
        if (mem_ready) begin
          w_next   = S_IDLE;
          w_retire = 1'b1;
        end
      end
      S_HALT, S_TRAP: w_next = r_state;
      default: w_next = S_IDLE;
    endcase
  end

  // r_fresh marks the first IDLE stay after reset,
  // the only time IDLE drives PC_CLR.
  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state   <= S_IDLE;
      r_fresh   <= 1'b1;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && run)
        r_fresh <= 1'b0;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_ctrl = '0;
    unique case (r_state)
      S_IDLE:   w_ctrl[PC_CLR] = r_fresh;
      S_FETCH:  w_ctrl[MAR_LD] = 1'b1;
      S_MEMRD:  w_ctrl[MEM_RD] = 1'b1;
      S_IRLD: begin
        w_ctrl[IR_LD]  = 1'b1;
        w_ctrl[PC_INC] = 1'b1;
      end
      S_DECODE: begin
        w_ctrl[ALU_OE] = 1'b1;
        w_ctrl[REG_RD] = 1'b1;
      end
      S_EX_ADD: begin
        w_ctrl[ALU_ADD] = 1'b1;
        w_ctrl[REG_WR]  = 1'b1;
      end
      S_EX_SUB: begin
        w_ctrl[ALU_SUB] = 1'b1;
        w_ctrl[REG_WR]  = 1'b1;
      end
      S_EX_LD: begin
        w_ctrl[MEM_RD] = 1'b1;
        w_ctrl[REG_WR] = 1'b1;
      end
      S_EX_ST:  w_ctrl[MEM_WR] = 1'b1;
      default:  w_ctrl = '0;
    endcase
  end

  assign control = w_ctrl;
  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;
`ifdef TRISC_CTRL_ILLEGAL_TRAP_EN
  assign trap = (r_state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_trisc_ctrl_seq.sv
// tb_trisc_ctrl_seq: directed + randomized bench for trisc_ctrl_seq.
// Expected control sequences are built per instruction from its phase list.
module tb_trisc_ctrl_seq;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        run = 1'b0;
  logic [10:0] op = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] control;
  logic        halted;
  logic        trap;
  logic [3:0]  retired;

  localparam logic [15:0] K_PCCLR  = 16'h0001;
  localparam logic [15:0] K_PCINC  = 16'h0002;
  localparam logic [15:0] K_IRLD   = 16'h0004;
  localparam logic [15:0] K_MARLD  = 16'h0008;
  localparam logic [15:0] K_MEMRD  = 16'h0010;
  localparam logic [15:0] K_REGRD  = 16'h0020;
  localparam logic [15:0] K_REGWR  = 16'h0040;
  localparam logic [15:0] K_ALUOE  = 16'h0080;
  localparam logic [15:0] K_ALUSUB = 16'h0100;
  localparam logic [15:0] K_ALUADD = 16'h0200;
  localparam logic [15:0] K_MEMWR  = 16'h0400;

  localparam logic [10:0] O_ADD = 11'b00000100000;
  localparam logic [10:0] O_SUB = 11'b00000010000;
  localparam logic [10:0] O_LD  = 11'b00000001000;
  localparam logic [10:0] O_ST  = 11'b00000000100;
  localparam logic [10:0] O_HLT = 11'b00000000001;

  int total = 0;
  int bad = 0;
  int exp_ret = 0;
  bit fresh = 1'b1;

  trisc_ctrl_seq #(
    .OP_W   (11),
    .CTRL_W (16),
    .CNT_W  (4)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .run       (run),
    .op        (op),
    .mem_ready (mem_ready),
    .control   (control),
    .halted    (halted),
    .trap      (trap),
    .retired   (retired)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 add, 1 sub, 2 ld, 3 st, 4 halt, 5 illegal
  function automatic int classify(input logic [10:0] o);
    if ($countones(o) != 1) return 5;
    if (o[5]) return 0;
    if (o[4]) return 1;
    if (o[3]) return 2;
    if (o[2]) return 3;
    if (o[0]) return 4;
    return 5;
  endfunction

  task automatic do_reset();
    #2;
    run = 1'b0;
    mem_ready = 1'b0;
    CLR = 1'b0;
    #1;
    chk("rst_ctrl", control, K_PCCLR);
    chk("rst_ret", retired, 0);
    chk("rst_halt", halted, 0);
    chk("rst_trap", trap, 0);
    exp_ret = 0;
    fresh = 1'b1;
    @(posedge CLK);
    #2 CLR = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      chk("gap_ctrl", control, fresh ? K_PCCLR : 16'h0);
      chk("gap_ret", retired, exp_ret);
      run = 1'b0;
      mem_ready = 1'($urandom);
    end
  endtask

  task automatic hold_check(input string tag, input bit is_trap);
    for (int i = 0; i < 5; i++) begin
      run = 1'($urandom);
      op = 11'($urandom);
      mem_ready = 1'($urandom);
      @(posedge CLK);
      chk({tag, "_ctrl"}, control, 0);
      chk({tag, "_flag"}, is_trap ? trap : halted, 1);
      chk({tag, "_ret"}, retired, exp_ret);
    end
  endtask

  task automatic do_instr(input logic [10:0] o, input int w1,
                          input int w2, input bit abort);
    int kind;
    kind = classify(o);
    @(posedge CLK);
    chk("idle_ctrl", control, fresh ? K_PCCLR : 16'h0);
    chk("idle_ret", retired, exp_ret);
    chk("idle_halt", halted, 0);
    chk("idle_trap", trap, 0);
    run = 1'b1;
    op = o;
    mem_ready = 1'($urandom);
    fresh = 1'b0;
    @(posedge CLK);
    chk("fetch", control, K_MARLD);
    run = 1'($urandom);
    for (int k = 0; k <= w1; k++) begin
      @(posedge CLK);
      chk("memrd", control, K_MEMRD);
      mem_ready = (k == w1);
    end
    @(posedge CLK);
    chk("irld", control, K_IRLD | K_PCINC);
    mem_ready = 1'($urandom);
    @(posedge CLK);
    chk("decode", control, K_ALUOE | K_REGRD);
    if (kind <= 1) begin
      @(posedge CLK);
      chk("ex_alu", control,
          (kind == 0 ? K_ALUADD : K_ALUSUB) | K_REGWR);
      chk("ex_ret", retired, exp_ret);
      exp_ret = (exp_ret + 1) % 16;
    end else if (kind <= 3) begin
      for (int k = 0; k <= w2; k++) begin
        @(posedge CLK);
        chk("ex_mem", control,
            kind == 2 ? (K_MEMRD | K_REGWR) : K_MEMWR);
        chk("ex_ret", retired, exp_ret);
        if (abort && k == 1) begin
          do_reset();
          return;
        end
        mem_ready = (k == w2);
      end
      exp_ret = (exp_ret + 1) % 16;
    end else if (kind == 4) begin
      @(posedge CLK);
      chk("halt_ctrl", control, 0);
      chk("halt_flag", halted, 1);
      hold_check("halt_hold", 1'b0);
      do_reset();
    end else begin
`ifdef TRISC_CTRL_ILLEGAL_TRAP_EN
      @(posedge CLK);
      chk("trap_flag", trap, 1);
      chk("trap_halt", halted, 0);
      hold_check("trap_hold", 1'b1);
      do_reset();
`else
      exp_ret = (exp_ret + 1) % 16;
`endif
    end
  endtask

  initial begin
    logic [10:0] o;
    int pick;
    do_reset();
    idle_gap(2);
    do_instr(O_ADD, 0, 0, 1'b0);
    idle_gap(1);
    do_instr(O_LD, 3, 2, 1'b0);
    idle_gap(2);
    do_instr(11'b00000110000, 0, 0, 1'b0);
    idle_gap(1);
    for (int n = 0; n < 30; n++) begin
`ifdef TRISC_CTRL_ILLEGAL_TRAP_EN
      pick = $urandom_range(0, 3);
`else
      pick = $urandom_range(0, 4);
`endif
      case (pick)
        0: o = O_ADD;
        1: o = O_SUB;
        2: o = O_LD;
        3: o = O_ST;
        default: begin
          o = 11'($urandom);
          if (classify(o) != 5) o = o | 11'h002;
        end
      endcase
      do_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end
    do_instr(O_HLT, 1, 0, 1'b0);
    for (int n = 0; n < 16; n++)
      do_instr(O_ADD, 0, 0, 1'b0);
    idle_gap(1);
    do_instr(O_SUB, 0, 0, 1'b0);
    do_instr(O_ST, 1, 3, 1'b1);
    idle_gap(2);
    do_instr(O_ST, 0, 1, 1'b0);
    idle_gap(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trisc_ctrl_seq.md
TRISC_CTRL_SEQ -- requirements
Module: trisc_ctrl_seq

Interface
REQ-001 SHALL have parameter OP_W, default 11, opcode field width (minimum 6).
REQ-002 SHALL have parameter CTRL_W, default 16, control word width (minimum 12).
REQ-003 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on falling edge.
REQ-005 SHALL have port CLR  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port run  input  1  level enable; low holds sequencer in IDLE between instructions.
REQ-007 SHALL have port op  input  OP_W  opcode from instruction register, one-hot.
REQ-008 SHALL have port mem_ready  input  1  memory handshake; high means access completes this cycle.
REQ-009 SHALL have port control  output  CTRL_W  datapath control word.
REQ-010 SHALL have port halted  output  1  high while in HALT.
REQ-011 SHALL have port trap  output  1  high while in TRAP; tied 0 when the trap feature is compiled out.
REQ-012 SHALL have port retired  output  CNT_W  count of completed instructions.

Function
REQ-013 SHALL implement states IDLE, FETCH, MEMRD, IRLD, DECODE, EX_ADD, EX_SUB, EX_LD, EX_ST, HALT, TRAP.
REQ-014 SHALL make control a Moore function of the state only; bits above the package-defined fields are 0.
REQ-015 Control per state SHALL be: IDLE=PC_CLR only after reset, otherwise 0; FETCH=MAR_LD; MEMRD=MEM_RD; IRLD=IR_LD|PC_INC; DECODE=ALU_OE|REG_RD; EX_ADD=ALU_ADD|REG_WR; EX_SUB=ALU_SUB|REG_WR; EX_LD=MEM_RD|REG_WR; EX_ST=MEM_WR; HALT=0; TRAP=0.
REQ-016 SHALL transition IDLE->FETCH when run=1, else stay in IDLE.
REQ-017 SHALL transition FETCH->MEMRD unconditionally, and IRLD->DECODE unconditionally.
REQ-018 SHALL stay in MEMRD while mem_ready=0 and go to IRLD when mem_ready=1.
REQ-019 SHALL decode in DECODE using op bit 5 -> EX_ADD, bit 4 -> EX_SUB, bit 3 -> EX_LD, bit 2 -> EX_ST, bit 0 -> HALT.
REQ-020 SHALL treat an op value that is not exactly one of those five one-hot codes (zero, multi-hot, other bit) as illegal.
REQ-021 SHALL return EX_ADD and EX_SUB to IDLE after one cycle.
REQ-022 SHALL hold EX_LD and EX_ST while mem_ready=0 and go to IDLE on mem_ready=1.
REQ-023 SHALL increment retired by 1 on each exit from an EX_* state to IDLE, wrapping from all-ones to 0.
REQ-024 SHALL hold HALT and TRAP until CLR; run and op SHALL be ignored there.
REQ-025 SHALL let a run deassertion take effect only in IDLE; an instruction in flight completes.
REQ-026 Nominal latency SHALL be 6 cycles for ADD/SUB and 6+wait cycles for LD/ST (IDLE..EX inclusive).

Reset
REQ-027 CLR=0 SHALL immediately force IDLE, retired=0, halted=0, trap=0 and control=PC_CLR, independent of CLK.
REQ-028 CLR asserted mid-instruction (including during a mem_ready wait) SHALL abandon it without incrementing retired.
REQ-029 After CLR release, IDLE SHALL output PC_CLR until the first exit from IDLE, then 0 on later IDLE visits.

Configuration
REQ-030 With macro TRISC_CTRL_ILLEGAL_TRAP_EN defined, an illegal op in DECODE SHALL go to TRAP and assert trap.
REQ-031 Without TRISC_CTRL_ILLEGAL_TRAP_EN, an illegal op SHALL go to IDLE as a NOP, SHALL increment retired, and trap SHALL stay 0.

Structure
REQ-032 Package trisc_ctrl_pkg SHALL hold the state encoding typedef, the opcode bit positions and the control-bit position constants (PC_CLR=0, PC_INC=1, MAR_LD=3, MEM_RD=4, IR_LD=2, ALU_OE=7, REG_RD=5, ALU_ADD=9, ALU_SUB=8, REG_WR=6, MEM_WR=10).
REQ-033 SHALL place the opcode legality and target decode in one combinational sub-module, trisc_op_decode.

Verification
REQ-034 Reset, run=1, op=11'b00000100000, mem_ready=1 -> IDLE,FETCH,MEMRD,IRLD,DECODE,EX_ADD,IDLE; retired=1.
REQ-035 LD op=11'b00000001000, mem_ready low 3 cycles in MEMRD and 2 in EX_LD -> MEM_RD held throughout; retired increments once.
REQ-036 op=11'b00000000001 -> HALT, halted=1; further run/op toggling gives no change until CLR.
REQ-037 op=11'b00000110000 with macro -> TRAP, trap=1, retired unchanged; without macro -> IDLE, retired+1.
REQ-038 CNT_W=4, 16 ADDs -> retired wraps to 0; CLR pulsed mid-EX_ST wait -> IDLE, control=PC_CLR, retired=0.
